// File: rtl/projeteis_pool_pkg.sv
// Shared constants and types for the projectile pool: coordinate width,
// screen size and the sweep FSM states.
package projeteis_pool_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        ATUALIZA = 1'b1
    } estado_t;

endpackage

// File: rtl/projeteis_pool_if.sv
// Bundle between the game logic (master) and the projectile pool (slave):
// fire handshake, enemy box, per-slot render bus and hit reporting.
interface projeteis_pool_if #(
    parameter int N_PROJ = 4,
    parameter int W      = 10
);
    logic                  pausa;
    logic                  tick_quadro;
    logic                  disparo_valido;
    logic                  disparo_pronto;
    logic [W-1:0]          x_disparo;
    logic [W-1:0]          y_disparo;
    logic [W-1:0]          x_inimigo;
    logic [W-1:0]          y_inimigo;
    logic [W-1:0]          largura_inimigo;
    logic [W-1:0]          altura_inimigo;
    logic [N_PROJ-1:0]     ativo_proj;
    logic [N_PROJ*W-1:0]   x_proj;
    logic [N_PROJ*W-1:0]   y_proj;
    logic                  acerto;
    logic [3:0]            indice_acerto;
    logic [7:0]            contagem_acertos;
    logic                  sobrecarga;

    modport master (
        output pausa, tick_quadro, disparo_valido, x_disparo, y_disparo,
               x_inimigo, y_inimigo, largura_inimigo, altura_inimigo,
        input  disparo_pronto, ativo_proj, x_proj, y_proj, acerto,
               indice_acerto, contagem_acertos, sobrecarga
    );

    modport slave (
        input  pausa, tick_quadro, disparo_valido, x_disparo, y_disparo,
               x_inimigo, y_inimigo, largura_inimigo, altura_inimigo,
        output disparo_pronto, ativo_proj, x_proj, y_proj, acerto,
               indice_acerto, contagem_acertos, sobrecarga
    );

endinterface

// File: rtl/projeteis_pool_colisao_caixa.sv
// Combinational overlap test of a round object (centre + radius) against an
// axis-aligned box; sums are widened by two bits so nothing wraps.
module colisao_caixa
    import projeteis_pool_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic [W-1:0] cx,
    input  logic [W-1:0] cy,
    input  logic [W-1:0] raio,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    input  logic [W-1:0] bl,
    input  logic [W-1:0] ba,
    output logic         sobrepoe
);
    localparam int WE = W + 2;

    logic [WE-1:0] cx_e, cy_e, raio_e, bx_e, by_e, bl_e, ba_e;

    assign cx_e   = WE'(cx);
    assign cy_e   = WE'(cy);
    assign raio_e = WE'(raio);
    assign bx_e   = WE'(bx);
    assign by_e   = WE'(by);
    assign bl_e   = WE'(bl);
    assign ba_e   = WE'(ba);

    assign sobrepoe = (cx_e + raio_e >= bx_e)
                   && (cx_e <= bx_e + bl_e + raio_e)
                   && (cy_e + raio_e >= by_e)
                   && (cy_e <= by_e + ba_e + raio_e);

endmodule

// File: rtl/projeteis_pool.sv
// Pool of N_PROJ upward-moving projectiles: accepts fire requests, sweeps one
// slot per cycle after each frame tick, and reports hits on the enemy box.
module projeteis_pool
    import projeteis_pool_pkg::*;
#(
    parameter int N_PROJ = 4,
    parameter int W      = COORD_W,
    parameter int VEL    = 4,
    parameter int RAIO   = 4
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    projeteis_pool_if.slave bus
);
    localparam int             IW           = (N_PROJ > 1) ? $clog2(N_PROJ) : 1;
    localparam logic [W+1:0]   LIMIAR_SAIDA = (W+2)'(VEL + RAIO);
    localparam logic [IW-1:0]  ULTIMO       = IW'(N_PROJ - 1);

    estado_t           estado_q, estado_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              acerto_q, acerto_d;
    logic [3:0]        indice_q, indice_d;
    logic [7:0]        contagem_q, contagem_d;
    logic              sobrecarga_q, sobrecarga_d;

    logic [N_PROJ-1:0] ativo_vec;
    logic [N_PROJ-1:0] livre;
    logic [N_PROJ-1:0] carga_oh;
    logic [W-1:0]      x_arr [N_PROJ];
    logic [W-1:0]      y_arr [N_PROJ];

    logic              atualizando;
    logic              tick_valido;
    logic              pronto;
    logic              transfere;
    logic [W-1:0]      x_sel, y_sel, y_novo_sel;
    logic              ativo_sel, saiu_sel, colide_sel, acerto_agora;

    assign atualizando = (estado_q == ATUALIZA);
    assign tick_valido = bus.tick_quadro && !bus.pausa;
    assign livre       = ~ativo_vec;
    assign pronto      = (estado_q == OCIOSO) && !bus.pausa && (|livre);
    assign transfere   = bus.disparo_valido && pronto;

    // Isolate the lowest set bit of the free mask: that slot takes the next shot.
    assign carga_oh    = livre & (~livre + N_PROJ'(1));

    // A single collision unit is time-shared across slots during the sweep.
    assign x_sel      = x_arr[idx_q];
    assign y_sel      = y_arr[idx_q];
    assign ativo_sel  = ativo_vec[idx_q];
    assign saiu_sel   = ({2'b00, y_sel} < LIMIAR_SAIDA);
    assign y_novo_sel = y_sel - W'(VEL);

    colisao_caixa #(.W(W)) u_colisao (
        .cx       (x_sel),
        .cy       (y_novo_sel),
        .raio     (W'(RAIO)),
        .bx       (bus.x_inimigo),
        .by       (bus.y_inimigo),
        .bl       (bus.largura_inimigo),
        .ba       (bus.altura_inimigo),
        .sobrepoe (colide_sel)
    );

    assign acerto_agora = atualizando && ativo_sel && !saiu_sel && colide_sel;

    for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_slot
        logic         ativo_q, ativo_d;
        logic [W-1:0] x_q, x_d, y_q, y_d;
        logic         processa;

        assign processa = atualizando && (idx_q == IW'(gi));

        always_comb begin
            ativo_d = ativo_q;
            x_d     = x_q;
            y_d     = y_q;
            if (transfere && carga_oh[gi]) begin
                ativo_d = 1'b1;
                x_d     = bus.x_disparo;
                y_d     = bus.y_disparo;
            end else if (processa && ativo_q) begin
                if (saiu_sel) begin
                    ativo_d = 1'b0;
                end else begin
                    y_d = y_novo_sel;
                    if (colide_sel) begin
                        ativo_d = 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                ativo_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
            end else begin
                ativo_q <= ativo_d;
                x_q     <= x_d;
                y_q     <= y_d;
            end
        end

        assign ativo_vec[gi]        = ativo_q;
        assign x_arr[gi]            = x_q;
        assign y_arr[gi]            = y_q;
        assign bus.x_proj[gi*W +: W] = x_q;
        assign bus.y_proj[gi*W +: W] = y_q;
    end

    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        acerto_d     = 1'b0;
        indice_d     = indice_q;
        contagem_d   = contagem_q;
        sobrecarga_d = sobrecarga_q;
        case (estado_q)
            OCIOSO: begin
                if (tick_valido) begin
                    estado_d = ATUALIZA;
                    idx_d    = '0;
                end
            end
            ATUALIZA: begin
                if (tick_valido) begin
                    sobrecarga_d = 1'b1;
                end
                if (acerto_agora) begin
                    acerto_d = 1'b1;
                    indice_d = 4'(idx_q);
                    if (contagem_q != 8'hFF) begin
                        contagem_d = contagem_q + 8'd1;
                    end
                end
                if (idx_q == ULTIMO) begin
                    estado_d = OCIOSO;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            idx_q        <= '0;
            acerto_q     <= 1'b0;
            indice_q     <= '0;
            contagem_q   <= '0;
            sobrecarga_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            acerto_q     <= acerto_d;
            indice_q     <= indice_d;
            contagem_q   <= contagem_d;
            sobrecarga_q <= sobrecarga_d;
        end
    end

    assign bus.disparo_pronto   = pronto;
    assign bus.ativo_proj       = ativo_vec;
    assign bus.acerto           = acerto_q;
    assign bus.indice_acerto    = indice_q;
    assign bus.contagem_acertos = contagem_q;
    assign bus.sobrecarga       = sobrecarga_q;

endmodule

// File: tb/tb_projeteis_pool.sv
// Randomised and directed bench for projeteis_pool against a frame-level
// reference model of the projectile slots, hit list and counters.
module tb_projeteis_pool;
    localparam int N    = 4;
    localparam int W    = 10;
    localparam int VEL  = 4;
    localparam int RAIO = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    projeteis_pool_if #(.N_PROJ(N), .W(W)) bus ();

    projeteis_pool #(.N_PROJ(N), .W(W), .VEL(VEL), .RAIO(RAIO)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_at [N];
    int m_x  [N];
    int m_y  [N];
    int m_cnt;
    int m_sobre;
    int bx, by, bw, bh;
    int exp_hits [$];
    int obs_hits [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.acerto === 1'b1)
            obs_hits.push_back(int'(bus.indice_acerto));
    end

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            m_at[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cnt = 0;
        m_sobre = 0;
        exp_hits.delete();
        obs_hits.delete();
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (m_at[i] == 0) return 1;
        return 0;
    endfunction

    function automatic void m_fire(input int x, input int y);
        for (int i = 0; i < N; i++) begin
            if (m_at[i] == 0) begin
                m_at[i] = 1; m_x[i] = x; m_y[i] = y;
                return;
            end
        end
    endfunction

    // One frame: every live projectile climbs VEL pixels or leaves the screen.
    function automatic void m_sweep();
        int yn;
        for (int i = 0; i < N; i++) begin
            if (m_at[i] != 0) begin
                if (m_y[i] < VEL + RAIO) begin
                    m_at[i] = 0;
                end else begin
                    yn = m_y[i] - VEL;
                    m_y[i] = yn;
                    if ((m_x[i] + RAIO >= bx) && (m_x[i] <= bx + bw + RAIO) &&
                        (yn + RAIO >= by) && (yn <= by + bh + RAIO)) begin
                        m_at[i] = 0;
                        exp_hits.push_back(i);
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    endfunction

    task automatic set_box(input int x, input int y, input int w, input int h);
        bx = x; by = y; bw = w; bh = h;
        bus.x_inimigo       = 10'(x);
        bus.y_inimigo       = 10'(y);
        bus.largura_inimigo = 10'(w);
        bus.altura_inimigo  = 10'(h);
    endtask

    task automatic compare_all();
        int n;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ativo%0d", i), int'(bus.ativo_proj[i]), m_at[i]);
            if (m_at[i] != 0) begin
                chk($sformatf("x%0d", i), int'(bus.x_proj[i*W +: W]), m_x[i]);
                chk($sformatf("y%0d", i), int'(bus.y_proj[i*W +: W]), m_y[i]);
            end
        end
        chk("contagem", int'(bus.contagem_acertos), m_cnt);
        chk("sobrecarga", int'(bus.sobrecarga), m_sobre);
        chk("n_acertos", obs_hits.size(), exp_hits.size());
        n = (obs_hits.size() < exp_hits.size()) ? obs_hits.size() : exp_hits.size();
        for (int k = 0; k < n; k++) chk("indice_acerto", obs_hits[k], exp_hits[k]);
        obs_hits.delete();
        exp_hits.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.disparo_valido = 1'b0;
        bus.tick_quadro    = 1'b0;
        bus.pausa          = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_clear();
    endtask

    task automatic do_fire(input int x, input int y);
        int exp_p;
        exp_p = (bus.pausa == 1'b0) ? m_free() : 0;
        bus.x_disparo = 10'(x);
        bus.y_disparo = 10'(y);
        bus.disparo_valido = 1'b1;
        @(negedge clk);
        chk("disparo_pronto", int'(bus.disparo_pronto), exp_p);
        @(posedge clk);
        #1 bus.disparo_valido = 1'b0;
        if (exp_p != 0) m_fire(x, y);
    endtask

    task automatic do_tick();
        logic p;
        p = bus.pausa;
        bus.tick_quadro = 1'b1;
        @(posedge clk);
        #1 bus.tick_quadro = 1'b0;
        repeat (N + 1) @(posedge clk);
        #1;
        if (p == 1'b0) m_sweep();
        compare_all();
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int r;
        bus.x_disparo = '0;
        bus.y_disparo = '0;
        set_box(600, 0, 10, 10);

        // Reset state
        do_reset();
        chk("reset_ativo", int'(bus.ativo_proj), 0);
        chk("reset_x", int'(bus.x_proj), 0);
        chk("reset_y", int'(bus.y_proj), 0);
        chk("reset_acerto", int'(bus.acerto), 0);
        compare_all();

        // Single shot climbing three frames
        do_fire(320, 400);
        compare_all();
        repeat (3) do_tick();
        chk("y_apos_3", int'(bus.y_proj[0 +: W]), 388);

        // Full pool holds the request until slot 2 leaves the screen
        do_reset();
        do_fire(100, 300);
        do_fire(200, 300);
        do_fire(300, 10);
        do_fire(400, 300);
        compare_all();
        bus.x_disparo = 10'd50;
        bus.y_disparo = 10'd200;
        bus.disparo_valido = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("pronto_cheio", int'(bus.disparo_pronto), 0);
        end
        @(posedge clk);
        #1;
        do_tick();
        bus.tick_quadro = 1'b1;
        @(posedge clk);
        #1 bus.tick_quadro = 1'b0;
        repeat (N) @(posedge clk);
        @(negedge clk);
        chk("pronto_liberado", int'(bus.disparo_pronto), 1);
        @(posedge clk);
        #1 bus.disparo_valido = 1'b0;
        m_sweep();
        m_fire(50, 200);
        compare_all();
        chk("slot2_x", int'(bus.x_proj[2*W +: W]), 50);

        // Enemy box hit on the second frame
        do_reset();
        set_box(300, 100, 40, 20);
        do_fire(320, 132);
        do_tick();
        do_tick();
        chk("contagem_1", int'(bus.contagem_acertos), 1);

        // Exit boundary: y=7 leaves, y=8 survives one more frame
        do_reset();
        set_box(600, 0, 10, 10);
        do_fire(100, 7);
        do_fire(200, 8);
        do_tick();
        do_tick();

        // Fire and tick together, then a tick mid-sweep
        do_reset();
        bus.x_disparo = 10'd200;
        bus.y_disparo = 10'd300;
        bus.disparo_valido = 1'b1;
        bus.tick_quadro = 1'b1;
        @(negedge clk);
        chk("pronto_tick", int'(bus.disparo_pronto), 1);
        @(posedge clk);
        #1;
        bus.disparo_valido = 1'b0;
        bus.tick_quadro = 1'b0;
        m_fire(200, 300);
        chk("sobrecarga_0", int'(bus.sobrecarga), 0);
        bus.tick_quadro = 1'b1;
        @(posedge clk);
        #1 bus.tick_quadro = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        m_sweep();
        m_sobre = 1;
        compare_all();

        // Randomised mix of shots, frames, box moves and pauses
        do_reset();
        set_box(300, 100, 40, 20);
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                do_fire(int'($urandom_range(280, 360)), int'($urandom_range(0, 220)));
                compare_all();
            end else if (r < 8) begin
                do_tick();
            end else if (r == 8) begin
                set_box(int'($urandom_range(250, 330)), int'($urandom_range(40, 160)),
                        int'($urandom_range(0, 60)), int'($urandom_range(0, 40)));
            end else begin
                bus.pausa = 1'b1;
                do_fire(int'($urandom_range(280, 360)), int'($urandom_range(0, 220)));
                do_tick();
                bus.pausa = 1'b0;
            end
        end

        // Counter saturation at 255
        do_reset();
        set_box(300, 100, 40, 20);
        guard = 0;
        while (m_cnt < 255 && guard < 80) begin
            repeat (N) do_fire(320, 128);
            do_tick();
            guard++;
        end
        chk("contagem_255", int'(bus.contagem_acertos), 255);
        repeat (N) do_fire(320, 128);
        do_tick();
        chk("contagem_sat", int'(bus.contagem_acertos), 255);

        // Reset in the middle of a sweep
        do_fire(320, 300);
        do_fire(330, 300);
        bus.tick_quadro = 1'b1;
        @(posedge clk);
        #1 bus.tick_quadro = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_clear();
        chk("rst_meio_ativo", int'(bus.ativo_proj), 0);
        chk("rst_meio_pronto", int'(bus.disparo_pronto), 1);
        chk("rst_meio_contagem", int'(bus.contagem_acertos), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_meio_ativo_depois", int'(bus.ativo_proj), 0);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
